// File: rtl/herculesae_vx_aes_round_seq.sv
// Iterative AES round scheduler: owns the 128-bit state and steps a shared
// combinational round datapath once per cycle, one block per command.
module herculesae_vx_aes_round_seq #(
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dec,
  input  logic [1:0]           cmd_nr,
  input  logic [127:0]         cmd_data,
  output logic [KEY_IDX_W-1:0] rk_idx,
  input  logic [127:0]         rk_data,
  output logic [127:0]         dp_in,
  output logic                 dp_dec,
  output logic                 dp_last,
  input  logic [127:0]         dp_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [127:0]         res_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [KEY_IDX_W-1:0] NR_128 = KEY_IDX_W'(10);
  localparam logic [KEY_IDX_W-1:0] NR_192 = KEY_IDX_W'(12);
  localparam logic [KEY_IDX_W-1:0] NR_256 = KEY_IDX_W'(14);

  state_t                 state_q, state_d;
  logic [127:0]           st_q, st_d;
  logic [KEY_IDX_W-1:0]   rnd_q, rnd_d;
  logic [KEY_IDX_W-1:0]   nr_q, nr_d;
  logic                   dec_q, dec_d;
  logic [KEY_IDX_W-1:0]   rk_idx_q;
  logic [KEY_IDX_W-1:0]   cmd_nr_val;
  logic                   accept;
  logic                   last_round;

  // Reserved key-size code 3 falls back to the 10-round schedule.
  always_comb begin
    case (cmd_nr)
      2'd1:    cmd_nr_val = NR_192;
      2'd2:    cmd_nr_val = NR_256;
      default: cmd_nr_val = NR_128;
    endcase
  end

  assign cmd_ready  = ~flush & ((state_q == IDLE) | ((state_q == DONE) & res_ready));
  assign accept     = cmd_valid & cmd_ready;
  assign last_round = (rnd_q == nr_q);

  assign dp_in      = st_q;
  assign dp_dec     = dec_q;
  assign dp_last    = (state_q == ROUND) & last_round;

  assign res_valid  = (state_q == DONE);
  assign res_data   = res_valid ? st_q : '0;
  assign busy       = (state_q != IDLE);

  // Decrypt walks the key schedule backwards; the accept cycle whitens
  // with the first key of the chosen direction.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rk_idx = rk_idx_q;
    if (accept) begin
      rk_idx = cmd_dec ? cmd_nr_val : '0;
    end else if (state_q == ROUND) begin
      rk_idx = dec_q ? (nr_q - rnd_q) : rnd_q;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    nr_d    = nr_q;
    dec_d   = dec_q;
    if (flush) begin
      // Abort drops any pending result; st keeps its contents.
      state_d = IDLE;
      rnd_d   = '0;
    end else if (accept) begin
      st_d    = cmd_data ^ rk_data;
      rnd_d   = KEY_IDX_W'(1);
      nr_d    = cmd_nr_val;
      dec_d   = cmd_dec;
      state_d = ROUND;
    end else begin
      case (state_q)
        ROUND: begin
          st_d = dp_out ^ rk_data;
          if (last_round) begin
            state_d = DONE;
          end else begin
            rnd_d = rnd_q + KEY_IDX_W'(1);
          end
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      // NOTE: the wide state register is cleared on reset too, so dp_in is
      // never X after reset.
      st_q     <= '0;
      rnd_q    <= '0;
      nr_q     <= NR_128;
      dec_q    <= 1'b0;
      rk_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      rnd_q    <= rnd_d;
      nr_q     <= nr_d;
      dec_q    <= dec_d;
      rk_idx_q <= rk_idx;
    end
  end

endmodule

// File: tb/tb_herculesae_vx_aes_round_seq.sv
// Self-checking bench: models the round datapath and key store around the
// scheduler and compares results against a plain FIPS-197 AES model.
module tb_herculesae_vx_aes_round_seq;

  logic         clk = 1'b0;
  logic         reset, flush, cmd_valid, cmd_dec, res_ready;
  logic [1:0]   cmd_nr;
  logic [127:0] cmd_data, rk_data, dp_in, dp_out, res_data;
  logic [3:0]   rk_idx;
  logic         cmd_ready, dp_dec, dp_last, res_valid, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] rk_eff [16];

  always #5 clk = ~clk;

  herculesae_vx_aes_round_seq #(.KEY_IDX_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dec(cmd_dec),
    .cmd_nr(cmd_nr), .cmd_data(cmd_data),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .dp_in(dp_in), .dp_dec(dp_dec), .dp_last(dp_last), .dp_out(dp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  // ---------------- GF(2^8) and AES primitives ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p, e;
    r = 8'h01; p = a; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a, input bit inv);
    logic [7:0] b;
    if (!inv) begin
      b = ginv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8], inv);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? r + 4 * ((c - r + 4) % 4) : r + 4 * ((c + r) % 4);
        o[8*(r + 4*c) +: 8] = s[8*src +: 8];
      end
    return o;
  endfunction

  function automatic logic [7:0] mix_coef(input bit inv, input int k);
    case (k)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[8*(4*c + j) +: 8], mix_coef(inv, (j - i + 4) % 4));
        o[8*(4*c + i) +: 8] = acc;
      end
    return o;
  endfunction

  // Round datapath as seen by the scheduler: no AddRoundKey.
  function automatic logic [127:0] dp_fn(input logic [127:0] x, input logic dec, input logic last);
    logic [127:0] y;
    if (!dec) begin
      y = shift_rows(sub_bytes(x, 1'b0), 1'b0);
      if (!last) y = mix_columns(y, 1'b0);
    end else begin
      y = sub_bytes(shift_rows(x, 1'b1), 1'b1);
      if (!last) y = mix_columns(y, 1'b1);
    end
    return y;
  endfunction

  function automatic int nr_of(input logic [1:0] nrsel);
    return (nrsel == 2'd1) ? 12 : (nrsel == 2'd2) ? 14 : 10;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24], 1'b0), sbox(w[23:16], 1'b0), sbox(w[15:8], 1'b0), sbox(w[7:0], 1'b0)};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rc};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endfunction

  // Textbook cipher / inverse cipher, used for expected results.
  function automatic logic [127:0] aes_ref(input bit dec, input logic [1:0] nrsel,
                                           input logic [255:0] key, input logic [127:0] data);
    int nr, nk;
    logic [127:0] s;
    nr = nr_of(nrsel);
    nk = nr - 6;
    if (!dec) begin
      s = data ^ round_key(key, nk, 0);
      for (int r = 1; r <= nr; r++) begin
        s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (r < nr) s = mix_columns(s, 1'b0);
        s = s ^ round_key(key, nk, r);
      end
    end else begin
      s = data ^ round_key(key, nk, nr);
      for (int r = nr - 1; r >= 0; r--) begin
        s = sub_bytes(shift_rows(s, 1'b1), 1'b1);
        s = s ^ round_key(key, nk, r);
        if (r > 0) s = mix_columns(s, 1'b1);
      end
    end
    return s;
  endfunction

  function automatic logic [255:0] kfh(input logic [255:0] h, input int nbytes);
    logic [255:0] o;
    o = '0;
    for (int i = 0; i < nbytes; i++) o[8*i +: 8] = h[8*(nbytes - 1 - i) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] blk(input logic [127:0] h);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = h[8*(15 - i) +: 8];
    return o;
  endfunction

  // Key store: decrypt middle rounds get InvMixColumns-folded keys so that
  // XOR after the inverse datapath matches the textbook inverse cipher.
  assign rk_data = rk_eff[rk_idx];
  assign dp_out  = dp_fn(dp_in, dp_dec, dp_last);

  task automatic load_env(input bit dec, input logic [1:0] nrsel, input logic [255:0] key);
    int nr;
    logic [127:0] k;
    nr = nr_of(nrsel);
    for (int i = 0; i < 16; i++) begin
      if (i > nr) begin
        rk_eff[i] = '0;
      end else begin
        k = round_key(key, nr - 6, i);
        rk_eff[i] = (dec && i != 0 && i != nr) ? mix_columns(k, 1'b1) : k;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string name);
    check(name, 256'({cmd_ready, res_valid, busy, dp_last, dp_dec, rk_idx, res_data}),
          256'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 128'h0}));
  endtask

  task automatic start_cmd(input bit dec, input logic [1:0] nrsel, input logic [255:0] key,
                           input logic [127:0] data, input bit from_done);
    int nr;
    nr = nr_of(nrsel);
    @(negedge clk);
    load_env(dec, nrsel, key);
    cmd_valid = 1'b1; cmd_dec = dec; cmd_nr = nrsel; cmd_data = data;
    res_ready = from_done;
    #1;
    check("accept_ready", 256'(cmd_ready), 256'(1));
    check("accept_rk_idx", 256'(rk_idx), 256'(dec ? nr : 0));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; res_ready = 1'b0;
    if (from_done) check("no_bubble", 256'({busy, res_valid}), 256'(2'b10));
  endtask

  task automatic finish_cmd(input bit dec, input logic [1:0] nrsel, input logic [127:0] exp);
    int nr, lat;
    logic [63:0] seq, exp_seq;
    logic [15:0] last_m, exp_last, dec_m, exp_dec;
    bit side;
    nr = nr_of(nrsel);
    lat = -1; side = 1'b0;
    seq = '0; exp_seq = '0; last_m = '0; exp_last = '0; dec_m = '0; exp_dec = '0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = n;
      end else begin
        if (n <= 15) begin
          seq[4*n +: 4] = rk_idx;
          last_m[n]     = dp_last;
          dec_m[n]      = dp_dec;
        end
        side = side | (res_data != 128'h0) | cmd_ready | !busy;
      end
    end
    for (int n = 1; n <= nr; n++) begin
      exp_seq[4*n +: 4] = dec ? 4'(nr - n) : 4'(n);
      exp_last[n]       = (n == nr);
      exp_dec[n]        = dec;
    end
    check("latency", 256'(lat), 256'(nr + 1));
    check("rk_idx_seq", 256'(seq), 256'(exp_seq));
    check("dp_last_mask", 256'(last_m), 256'(exp_last));
    check("dp_dec_mask", 256'(dec_m), 256'(exp_dec));
    check("round_side_outputs", 256'(side), 256'(0));
    check("res_data", 256'(res_data), 256'(exp));
  endtask

  task automatic drain();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("drain_idle", 256'({busy, res_valid}), 256'(0));
  endtask

  typedef struct {
    bit           dec;
    logic [1:0]   nrsel;
    logic [255:0] key;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [255:0] k128, k192, k256, key;
    logic [127:0] pt, c128, c192, c256, data, exp;
    bit           dec, seen;
    logic [1:0]   nrsel;

    k128 = kfh(256'h000102030405060708090a0b0c0d0e0f, 16);
    k192 = kfh(256'h000102030405060708090a0b0c0d0e0f1011121314151617, 24);
    k256 = kfh(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 32);
    pt   = blk(128'h00112233445566778899aabbccddeeff);
    c128 = blk(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    c192 = blk(128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    c256 = blk(128'h8ea2b7ca516745bfeafc49904b496089);
    vecs[0] = '{dec: 1'b0, nrsel: 2'd0, key: k128, data: pt,   exp: c128};
    vecs[1] = '{dec: 1'b1, nrsel: 2'd0, key: k128, data: c128, exp: pt};
    vecs[2] = '{dec: 1'b0, nrsel: 2'd1, key: k192, data: pt,   exp: c192};
    vecs[3] = '{dec: 1'b1, nrsel: 2'd1, key: k192, data: c192, exp: pt};
    vecs[4] = '{dec: 1'b0, nrsel: 2'd2, key: k256, data: pt,   exp: c256};
    vecs[5] = '{dec: 1'b1, nrsel: 2'd2, key: k256, data: c256, exp: pt};
    vecs[6] = '{dec: 1'b0, nrsel: 2'd3, key: k128, data: pt,   exp: c128};

    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_dec = 1'b0; cmd_nr = 2'd0;
    cmd_data = '0; res_ready = 1'b0;
    for (int i = 0; i < 16; i++) rk_eff[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Known-answer vectors, all key sizes, both directions, reserved code.
    for (int v = 0; v < 7; v++) begin
      start_cmd(vecs[v].dec, vecs[v].nrsel, vecs[v].key, vecs[v].data, 1'b0);
      finish_cmd(vecs[v].dec, vecs[v].nrsel, vecs[v].exp);
      drain();
    end

    // Back-pressure in DONE, then a back-to-back command on the release cycle.
    start_cmd(1'b0, 2'd0, k128, pt, 1'b0);
    finish_cmd(1'b0, 2'd0, c128);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", 256'({cmd_ready, res_valid, res_data}), 256'({1'b0, 1'b1, c128}));
    end
    start_cmd(1'b1, 2'd2, k256, c256, 1'b1);
    finish_cmd(1'b1, 2'd2, pt);
    drain();

    // Flush at round 4 of AES-192.
    start_cmd(1'b0, 2'd1, k192, pt, 1'b0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush_idle", 256'({busy, cmd_ready, res_valid}), 256'(3'b010));
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | res_valid;
    end
    check("flush_no_result", 256'(seen), 256'(0));
    start_cmd(1'b0, 2'd0, k128, pt, 1'b0);
    finish_cmd(1'b0, 2'd0, c128);
    drain();

    // Reset mid-operation with cmd_valid held.
    start_cmd(1'b1, 2'd2, k256, c256, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b1; cmd_dec = 1'b0; cmd_nr = 2'd0; cmd_data = pt;
    @(posedge clk);
    #1;
    check_reset_outs("reset_mid");
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reset_no_accept", 256'(busy), 256'(0));

    // Reset and flush together during a decrypt.
    start_cmd(1'b1, 2'd0, k128, c128, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; flush = 1'b0;
    #1;
    check_reset_outs("reset_flush");

    // Randomised blocks against the reference model.
    repeat (20) begin
      dec   = 1'($urandom_range(0, 1));
      nrsel = 2'($urandom_range(0, 3));
      for (int k = 0; k < 8; k++) key[32*k +: 32] = $urandom();
      for (int k = 0; k < 4; k++) data[32*k +: 32] = $urandom();
      exp = aes_ref(dec, nrsel, key, data);
      start_cmd(dec, nrsel, key, data, 1'b0);
      finish_cmd(dec, nrsel, exp);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rand_hold", 256'(res_data), 256'(exp));
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
